// File: rtl/ss_pipe_pkg.sv
// Shared types for the superscalar issue stage: register width, issue FSM
// states, the per-lane E-stage bundle and its bubble value.
// Optional feature macro: SS_ISSUE_WAW_SPLIT_EN (split same-destination pairs).
package ss_pipe_pkg;

  localparam int REG_AW    = 5;
  localparam int PAYLOAD_W = 64;

`ifdef SS_ISSUE_WAW_SPLIT_EN
  localparam logic WAW_SPLIT = 1'b1;
`else
  localparam logic WAW_SPLIT = 1'b0;
`endif

  typedef enum logic {
    PAIR = 1'b0,
    HALF = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_AW-1:0]    rs;
    logic [REG_AW-1:0]    rt;
    logic [REG_AW-1:0]    wreg;
    logic                 regwrite;
    logic                 memtoreg;
    logic [PAYLOAD_W-1:0] payload;
  } lane_t;

  localparam lane_t LANE_BUBBLE = '0;

  // True when an E-stage load will write src; register 0 never hazards.
  function automatic logic load_hit(input logic v, input logic m2r,
                                    input logic [REG_AW-1:0] wreg,
                                    input logic [REG_AW-1:0] src);
    return v & m2r & (wreg != '0) & (wreg == src);
  endfunction

endpackage

// File: rtl/ss_pair_hazard.sv
// Combinational hazard classifier for the decode pair against the E lanes.
// With SS_ISSUE_WAW_SPLIT_EN defined, same-destination pairs also split.
module ss_pair_hazard
  import ss_pipe_pkg::*;
(
  input  logic              valid_e1,
  input  logic              memtoreg_e1,
  input  logic [REG_AW-1:0] wreg_e1,
  input  logic              valid_e2,
  input  logic              memtoreg_e2,
  input  logic [REG_AW-1:0] wreg_e2,
  input  logic [REG_AW-1:0] rs_d1,
  input  logic [REG_AW-1:0] rt_d1,
  input  logic [REG_AW-1:0] wreg_d1,
  input  logic              regwrite_d1,
  input  logic              memtoreg_d1,
  input  logic              memop_d1,
  input  logic [REG_AW-1:0] rs_d2,
  input  logic [REG_AW-1:0] rt_d2,
  input  logic [REG_AW-1:0] wreg_d2,
  input  logic              regwrite_d2,
  input  logic              memop_d2,
  output logic              load_use_all,
  output logic              load_use_s2,
  output logic              pair_conflict
);

  logic lu_s1;
  logic intra_load;
  logic waw;

  // Classify load-use per slot and the intra-pair conflicts.
  always_comb begin
    lu_s1 = load_hit(valid_e1, memtoreg_e1, wreg_e1, rs_d1) |
            load_hit(valid_e1, memtoreg_e1, wreg_e1, rt_d1) |
            load_hit(valid_e2, memtoreg_e2, wreg_e2, rs_d1) |
            load_hit(valid_e2, memtoreg_e2, wreg_e2, rt_d1);
    load_use_s2 = load_hit(valid_e1, memtoreg_e1, wreg_e1, rs_d2) |
                  load_hit(valid_e1, memtoreg_e1, wreg_e1, rt_d2) |
                  load_hit(valid_e2, memtoreg_e2, wreg_e2, rs_d2) |
                  load_hit(valid_e2, memtoreg_e2, wreg_e2, rt_d2);
    load_use_all = lu_s1 | load_use_s2;
    intra_load   = memtoreg_d1 & (wreg_d1 != '0) &
                   ((wreg_d1 == rs_d2) | (wreg_d1 == rt_d2));
    waw          = regwrite_d1 & regwrite_d2 & (wreg_d1 == wreg_d2) &
                   (wreg_d1 != '0);
    pair_conflict = (memop_d1 & memop_d2) | intra_load | (WAW_SPLIT & waw);
  end

endmodule

// File: rtl/ss_issue_stage.sv
// Dual-issue D->E issue stage: PAIR/HALF issue FSM plus the two E-stage lane
// registers. Slot 1 only enters lane 1, slot 2 only lane 2.
// Optional feature macro: SS_ISSUE_WAW_SPLIT_EN (see ss_pair_hazard).
module ss_issue_stage
  import ss_pipe_pkg::*;
#(
  parameter int REG_AW    = ss_pipe_pkg::REG_AW,
  parameter int PAYLOAD_W = ss_pipe_pkg::PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 InstrValidD,
  input  logic [REG_AW-1:0]    RsD1,
  input  logic [REG_AW-1:0]    RtD1,
  input  logic [REG_AW-1:0]    WriteRegD1,
  input  logic                 RegWriteD1,
  input  logic                 MemToRegD1,
  input  logic                 MemOpD1,
  input  logic [REG_AW-1:0]    RsD2,
  input  logic [REG_AW-1:0]    RtD2,
  input  logic [REG_AW-1:0]    WriteRegD2,
  input  logic                 RegWriteD2,
  input  logic                 MemToRegD2,
  input  logic                 MemOpD2,
  input  logic [PAYLOAD_W-1:0] PayloadD1,
  input  logic [PAYLOAD_W-1:0] PayloadD2,
  input  logic                 FlushE,
  output logic                 StallD,
  output logic                 ValidE1,
  output logic                 ValidE2,
  output logic [REG_AW-1:0]    Rd1e1,
  output logic [REG_AW-1:0]    Rd2e1,
  output logic [REG_AW-1:0]    Rd1e2,
  output logic [REG_AW-1:0]    Rd2e2,
  output logic [REG_AW-1:0]    WriteRegE1,
  output logic [REG_AW-1:0]    WriteRegE2,
  output logic                 RegWriteE1,
  output logic                 RegWriteE2,
  output logic                 MemToRegE1,
  output logic                 MemToRegE2,
  output logic [PAYLOAD_W-1:0] PayloadE1,
  output logic [PAYLOAD_W-1:0] PayloadE2
);

  issue_state_e state_q, state_d;
  lane_t        lane1_q, lane1_d, lane2_q, lane2_d;
  lane_t        slot1, slot2;
  logic         stall;
  logic         load_use_all, load_use_s2, pair_conflict;

  assign slot1 = '{valid: 1'b1, rs: RsD1, rt: RtD1, wreg: WriteRegD1,
                   regwrite: RegWriteD1, memtoreg: MemToRegD1, payload: PayloadD1};
  assign slot2 = '{valid: 1'b1, rs: RsD2, rt: RtD2, wreg: WriteRegD2,
                   regwrite: RegWriteD2, memtoreg: MemToRegD2, payload: PayloadD2};

  ss_pair_hazard u_hazard (
    .valid_e1      (lane1_q.valid),
    .memtoreg_e1   (lane1_q.memtoreg),
    .wreg_e1       (lane1_q.wreg),
    .valid_e2      (lane2_q.valid),
    .memtoreg_e2   (lane2_q.memtoreg),
    .wreg_e2       (lane2_q.wreg),
    .rs_d1         (RsD1),
    .rt_d1         (RtD1),
    .wreg_d1       (WriteRegD1),
    .regwrite_d1   (RegWriteD1),
    .memtoreg_d1   (MemToRegD1),
    .memop_d1      (MemOpD1),
    .rs_d2         (RsD2),
    .rt_d2         (RtD2),
    .wreg_d2       (WriteRegD2),
    .regwrite_d2   (RegWriteD2),
    .memop_d2      (MemOpD2),
    .load_use_all  (load_use_all),
    .load_use_s2   (load_use_s2),
    .pair_conflict (pair_conflict)
  );

  // Issue decision: flush beats every hazard; otherwise pick lanes per state.
  always_comb begin
    state_d = state_q;
    lane1_d = LANE_BUBBLE;
    lane2_d = LANE_BUBBLE;
    stall   = 1'b0;
    if (FlushE) begin
      state_d = PAIR;
    end else begin
      case (state_q)
        PAIR: begin
          if (InstrValidD) begin
            if (load_use_all) begin
              stall = 1'b1;
            end else if (pair_conflict) begin
              lane1_d = slot1;
              stall   = 1'b1;
              state_d = HALF;
            end else begin
              lane1_d = slot1;
              lane2_d = slot2;
            end
          end
        end
        HALF: begin
          if (load_use_s2) begin
            stall = 1'b1;
          end else begin
            lane2_d = slot2;
            state_d = PAIR;
          end
        end
        default: state_d = PAIR;
      endcase
    end
  end

  // State and E-stage lane registers; reset drops any pending slot 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PAIR;
      lane1_q <= LANE_BUBBLE;
      lane2_q <= LANE_BUBBLE;
    end else begin
      state_q <= state_d;
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
    end
  end

  assign StallD     = stall & rst_n;
  assign ValidE1    = lane1_q.valid;
  assign ValidE2    = lane2_q.valid;
  assign Rd1e1      = lane1_q.rs;
  assign Rd2e1      = lane1_q.rt;
  assign Rd1e2      = lane2_q.rs;
  assign Rd2e2      = lane2_q.rt;
  assign WriteRegE1 = lane1_q.wreg;
  assign WriteRegE2 = lane2_q.wreg;
  assign RegWriteE1 = lane1_q.regwrite;
  assign RegWriteE2 = lane2_q.regwrite;
  assign MemToRegE1 = lane1_q.memtoreg;
  assign MemToRegE2 = lane2_q.memtoreg;
  assign PayloadE1  = lane1_q.payload;
  assign PayloadE2  = lane2_q.payload;

endmodule
